// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared FSM encoding and NOP word for the fetch unit
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory bus and IF/ID register bundle
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;

    modport master (
        output imem_addr,
        input  imem_data,
        output if_instr,
        output if_pc,
        output if_valid
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_instr,
        input  if_pc,
        input  if_valid
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_addr_check.sv
// rtl/instruction_fetch_unit_fetch_addr_check.sv - word-aligned, in-range fetch address test
module fetch_addr_check #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic [31:0] addr,
    output logic        legal
);

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    logic [32:0] end_addr;

    assign end_addr = {1'b0, addr} + 33'd4;
    assign legal    = (addr[1:0] == 2'b00) && (end_addr <= 33'(MEM_BYTES));

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-stage fetch with IF/ID register, stall, branch and fault halt
module instruction_fetch_unit #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = instruction_fetch_unit_pkg::NOP_WORD
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stall,
    input  logic                            branch_taken,
    input  logic [31:0]                     branch_target,
    instruction_fetch_unit_if.master        bus,
    output logic                            fault,
    output logic [31:0]                     fault_addr,
    output logic [31:0]                     fetch_count
);

    import instruction_fetch_unit_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] faddr_q, faddr_d;
    logic [31:0] count_q, count_d;
    logic        pc_legal;
    logic        target_legal;

    fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_pc_check (
        .addr  (pc_q),
        .legal (pc_legal)
    );

    fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_target_check (
        .addr  (branch_target),
        .legal (target_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ifpc_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            faddr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        faddr_d = faddr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                // a redirect outranks a decode stall
                if (branch_taken) begin
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    if (target_legal) begin
                        pc_d = branch_target;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        faddr_d = branch_target;
                    end
                end else if (!stall) begin
                    if (pc_legal) begin
                        instr_d = bus.imem_data;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        count_d = count_q + 32'd1;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        faddr_d = pc_q;
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_valid  = valid_q;
    assign fault         = fault_q;
    assign fault_addr    = faddr_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;
    logic [31:0] mem [16];
    int          checks;
    int          errors;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .MEM_BYTES (64),
        .RESET_PC  (32'h0000_0000),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .bus           (bus),
        .fault         (fault),
        .fault_addr    (fault_addr),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (bus.imem_addr < 32'd64 && bus.imem_addr[1:0] == 2'b00)
            bus.imem_data = mem[bus.imem_addr[5:2]];
        else
            bus.imem_data = 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", bus.if_instr, 32'h0); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_ifpc got %h exp %h", bus.if_pc, 32'h0); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        checks++; if (fault_addr !== 32'h0) begin errors++; $display("FAIL reset_faddr got %h exp 0", fault_addr); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", fetch_count); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL idle_hold got addr %h valid %b exp 0 0", bus.imem_addr, bus.if_valid); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h0000_00FF; exp_instr[1] = 32'h0000_FF00;
        exp_instr[2] = 32'h00FF_0000; exp_instr[3] = 32'hFF00_0000;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (bus.if_valid !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL start_cycle got valid %b count %0d exp 0 0", bus.if_valid, fetch_count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.if_instr !== exp_instr[i]) begin errors++; $display("FAIL run_instr%0d got %h exp %h", i, bus.if_instr, exp_instr[i]); end
            checks++; if (bus.if_pc !== 32'(i * 4)) begin errors++; $display("FAIL run_pc%0d got %h exp %h", i, bus.if_pc, 32'(i * 4)); end
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL run_valid%0d got %b exp 1", i, bus.if_valid); end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL run_count got %0d exp 4", fetch_count); end
        checks++; if (bus.imem_addr !== 32'd16) begin errors++; $display("FAIL run_addr got %h exp 10", bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.if_instr !== 32'h0000_FF00 || bus.if_pc !== 32'd4) begin errors++; $display("FAIL stall_ifid%0d got %h@%h exp 0000ff00@4", i, bus.if_instr, bus.if_pc); end
            checks++; if (bus.imem_addr !== 32'd8 || fetch_count !== 32'd2) begin errors++; $display("FAIL stall_pc%0d got pc %h count %0d exp 8 2", i, bus.imem_addr, fetch_count); end
        end
        stall = 1'b0;
        tick();
        checks++; if (bus.if_instr !== 32'h00FF_0000 || bus.if_pc !== 32'd8 || fetch_count !== 32'd3) begin errors++; $display("FAIL stall_resume got %h@%h count %0d exp 00ff0000@8 3", bus.if_instr, bus.if_pc, fetch_count); end
    endtask

    task automatic test_branch_over_stall();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        branch_taken = 1'b1; stall = 1'b1; branch_target = 32'd12;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0) begin errors++; $display("FAIL branch_bubble got valid %b instr %h exp 0 0", bus.if_valid, bus.if_instr); end
        checks++; if (bus.imem_addr !== 32'd12 || fetch_count !== 32'd1) begin errors++; $display("FAIL branch_pc got pc %h count %0d exp c 1", bus.imem_addr, fetch_count); end
        tick();
        checks++; if (bus.if_instr !== 32'hFF00_0000 || bus.if_pc !== 32'd12 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL branch_fetch got %h@%h v%b exp ff000000@c v1", bus.if_instr, bus.if_pc, bus.if_valid); end
    endtask

    task automatic test_branch_fault_and_halt();
        branch_taken = 1'b1; branch_target = 32'h6;
        tick();
        checks++; if (fault !== 1'b1 || fault_addr !== 32'h6 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL branch_fault got f%b addr %h v%b exp f1 6 v0", fault, fault_addr, bus.if_valid); end
        start = 1'b1; branch_target = 32'h0;
        tick();
        tick();
        start = 1'b0; branch_taken = 1'b0;
        checks++; if (fault !== 1'b1 || fault_addr !== 32'h6 || bus.imem_addr !== 32'd16 || fetch_count !== 32'd2) begin errors++; $display("FAIL halt_hold got f%b addr %h pc %h count %0d exp f1 6 10 2", fault, fault_addr, bus.imem_addr, fetch_count); end
    endtask

    task automatic test_reset_in_halt();
        rst_n = 1'b0; start = 1'b1; branch_taken = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0; branch_taken = 1'b0;
        checks++; if (fault !== 1'b0 || fault_addr !== 32'h0 || fetch_count !== 32'h0) begin errors++; $display("FAIL halt_reset got f%b addr %h count %0d exp 0 0 0", fault, fault_addr, fetch_count); end
        checks++; if (bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL halt_reset_ifid got pc %h v%b %h@%h exp all 0", bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc); end
        tick();
        checks++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL halt_reset_idle got v%b pc %h exp 0 0", bus.if_valid, bus.imem_addr); end
    endtask

    task automatic test_end_of_mem();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        branch_taken = 1'b1; branch_target = 32'd60;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++; if (bus.if_instr !== 32'hAAAA_0060 || bus.if_pc !== 32'd60 || fetch_count !== 32'd1) begin errors++; $display("FAIL last_word got %h@%h count %0d exp aaaa0060@3c 1", bus.if_instr, bus.if_pc, fetch_count); end
        tick();
        checks++; if (fault !== 1'b1 || fault_addr !== 32'd64 || bus.if_valid !== 1'b0 || fetch_count !== 32'd1) begin errors++; $display("FAIL end_fault got f%b addr %h v%b count %0d exp f1 40 v0 1", fault, fault_addr, bus.if_valid, fetch_count); end
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stall = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || fetch_count !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stall_reset got v%b %h@%h count %0d pc %h exp all 0", bus.if_valid, bus.if_instr, bus.if_pc, fetch_count, bus.imem_addr); end
        stall = 1'b0;
        tick();
        tick();
        checks++; if (bus.if_valid !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL stall_reset_idle got v%b count %0d exp 0 0", bus.if_valid, fetch_count); end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checks++; if (bus.if_instr !== 32'h0000_00FF || bus.if_pc !== 32'h0 || fetch_count !== 32'd1) begin errors++; $display("FAIL restart got %h@%h count %0d exp 000000ff@0 1", bus.if_instr, bus.if_pc, fetch_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'h0000_00FF;
        mem[1]  = 32'h0000_FF00;
        mem[2]  = 32'h00FF_0000;
        mem[3]  = 32'hFF00_0000;
        mem[15] = 32'hAAAA_0060;
        test_reset();
        test_free_run();
        test_stall();
        test_branch_over_stall();
        test_branch_fault_and_halt();
        test_reset_in_halt();
        test_end_of_mem();
        test_reset_in_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter MEM_BYTES, default 64, instruction memory size in bytes.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter NOP_WORD, default 32'h0000_0000, instruction driven when the IF/ID register is invalid.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 START  input  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-007 STALL  input  1  hazard hold from decode; freezes PC and IF/ID.
REQ-008 BRANCH_TAKEN  input  1  redirect request from execute.
REQ-009 BRANCH_TARGET  input  32  byte address of redirect.
REQ-010 IMEM_ADDR  output  32  byte address to instruction memory; equals PC, combinational.
REQ-011 IMEM_DATA  input  32  little-endian word returned combinationally for IMEM_ADDR.
REQ-012 IF_INSTR  output  32  registered instruction to decode.
REQ-013 IF_PC  output  32  registered address of IF_INSTR.
REQ-014 IF_VALID  output  1  IF_INSTR is a real fetched instruction.
REQ-015 FAULT  output  1  fetch fault latched; unit halted.
REQ-016 FAULT_ADDR  output  32  address that caused the fault.
REQ-017 FETCH_COUNT  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, HALT; reset enters IDLE.
REQ-019 IDLE: PC holds; IF_VALID=0; START=1 moves to RUN at the next edge.
REQ-020 RUN: an address A is legal when A[1:0]==0 and A+4 <= MEM_BYTES.
REQ-021 RUN, STALL=0, BRANCH_TAKEN=0, PC legal: at the edge, IF_INSTR<=IMEM_DATA, IF_PC<=PC, IF_VALID<=1, PC<=PC+4, FETCH_COUNT+=1.
REQ-022 Fetch latency: an instruction at PC in cycle n SHALL appear on IF_INSTR in cycle n+1.
REQ-023 RUN, STALL=1, BRANCH_TAKEN=0: PC, IF_INSTR, IF_PC, IF_VALID and FETCH_COUNT hold.
REQ-024 BRANCH_TAKEN=1 in RUN (STALL ignored): PC<=BRANCH_TARGET, IF_VALID<=0, IF_INSTR<=NOP_WORD; the count does not increment. Branch has priority over stall.
REQ-025 A branch to an illegal target SHALL give HALT next cycle: FAULT=1, FAULT_ADDR=BRANCH_TARGET, IF_VALID=0.
REQ-026 RUN with an illegal PC and no branch SHALL give HALT: FAULT=1, FAULT_ADDR=PC, IF_VALID=0, and no fetch.
REQ-027 HALT: all state holds until reset; START, STALL and BRANCH_TAKEN are ignored.
REQ-028 PC+4 SHALL use 32-bit unsigned arithmetic; overflow is caught by the legality check, not wrapped silently into range.
REQ-029 FETCH_COUNT SHALL wrap modulo 2^32.
REQ-030 START while in RUN or HALT SHALL be ignored.

Reset
REQ-031 When RST_N=0 at an edge: state=IDLE, PC=RESET_PC, IF_INSTR=NOP_WORD, IF_PC=0, IF_VALID=0, FAULT=0, FAULT_ADDR=0, FETCH_COUNT=0.
REQ-032 Reset SHALL override every other input in any state, including mid-stall and HALT.
REQ-033 IMEM_ADDR SHALL equal RESET_PC during and immediately after reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2) and NOP_WORD.
REQ-035 One sub-module, fetch_addr_check, SHALL compute address legality for both PC and BRANCH_TARGET.
REQ-036 The instruction memory SHALL stay external; this block SHALL NOT instantiate it.

Verification
REQ-037 Use a memory image with word@0=0x000000FF, @4=0x0000FF00, @8=0x00FF0000, @12=0xFF000000. Reset, START, 4 free-run cycles -> IF_INSTR sequence 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000 with IF_PC 0, 4, 8, 12, and FETCH_COUNT=4.
REQ-038 STALL=1 for 3 cycles after the fetch at PC=4 -> IF_INSTR stays 0x0000FF00, PC stays 8, count frozen; fetching resumes at 8 on release.
REQ-039 BRANCH_TAKEN=1 with STALL=1 and target 12 -> next cycle IF_VALID=0 and IF_INSTR=NOP_WORD; the following cycle IF_INSTR=0xFF000000 and IF_PC=12.
REQ-040 Branch to 0x6 -> FAULT=1, FAULT_ADDR=0x6, HALT. Separately, run from 60 with MEM_BYTES=64 -> fetch at 60 succeeds, then FAULT with FAULT_ADDR=64.
REQ-041 Assert RST_N=0 while in HALT, and again during a stall -> all outputs match REQ-031 next cycle and the state is IDLE.
